// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver: off / on / lock-step blink / Ethernet-activity flash per channel.
// Optional LED_PWM_EN adds a per-channel brightness input and a free-running PWM counter.
module led_status_ctrl #(
    parameter int CHANNELS      = 4,
    parameter int TICK_DIV      = 125_000,
    parameter int BLINK_TICKS   = 500,
    parameter int STRETCH_TICKS = 50,
    parameter int PWM_BITS      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [CHANNELS-1:0]          activity,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS*CHANNELS-1:0] brightness,
`endif
    output logic [CHANNELS-1:0]          led,
    output logic                         tick_o
);

    localparam int PRE_W   = $clog2(TICK_DIV + 1);
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
    localparam int STR_W   = $clog2(STRETCH_TICKS + 1);

    localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [STR_W-1:0]   STR_LOAD  = STR_W'(STRETCH_TICKS);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_ACT   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFF,
        ST_HOLD
    } act_state_t;

    generate
        if (CHANNELS < 1 || TICK_DIV < 2 || BLINK_TICKS < 1 ||
            STRETCH_TICKS < 1 || PWM_BITS < 1) begin : g_param_check
            $error("led_status_ctrl: parameter out of range");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] presc_q;
    logic             presc_wrap;

    assign presc_wrap = (presc_q == PRE_MAX);

    // NOTE: reset is synchronous here, so it lives inside the clocked branch and
    // state uses non-blocking assignments to avoid read/write races between blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick_o  <= 1'b0;
        end else begin
            presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
            tick_o  <= presc_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Shared blink phase: every blink channel reads the same phase bit
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (tick_o) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel mode decode and activity FSM
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] lit;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mode_t      ch_mode;
        act_state_t state_q, state_d;
        logic [STR_W-1:0] cnt_q, cnt_d;
        logic       pend_q, pend_d;
        logic       ch_lit;

        assign ch_mode = mode_t'(mode[2*i +: 2]);

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            if (ch_mode != MODE_ACT) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end else begin
                unique case (state_q)
                    // A tick coinciding with the strobe is not counted against the fresh load.
                    ST_IDLE: begin
                        if (activity[i]) begin
                            state_d = ST_OFF;
                            cnt_d   = STR_LOAD;
                        end
                    end
                    ST_OFF: begin
                        if (cnt_q == '0) begin
                            state_d = ST_HOLD;
                            cnt_d   = STR_LOAD;
                        end else if (tick_o) begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_q == '0) begin
                            pend_d = 1'b0;
                            if (pend_q || activity[i]) begin
                                state_d = ST_OFF;
                                cnt_d   = STR_LOAD;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            if (activity[i]) pend_d = 1'b1;
                            if (tick_o)      cnt_d  = cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end
                endcase
            end
        end

        // Blink reads the next phase so a wrap and a mode change on the same edge agree.
        always_comb begin
            ch_lit = 1'b0;
            unique case (ch_mode)
                MODE_OFF:   ch_lit = 1'b0;
                MODE_ON:    ch_lit = 1'b1;
                MODE_BLINK: ch_lit = ~phase_d;
                MODE_ACT:   ch_lit = (state_q != ST_OFF);
                default:    ch_lit = 1'b0;
            endcase
        end

        assign lit[i] = ch_lit;
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] led_d;

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_q;
    logic [CHANNELS-1:0] pwm_on;

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_q + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_pwm
        assign pwm_on[i] = (pwm_q < brightness[i*PWM_BITS +: PWM_BITS]);
    end

    assign led_d = lit & pwm_on;
`else
    assign led_d = lit;
`endif

    always_ff @(posedge clk) begin
        if (rst) led <= '0;
        else     led <= led_d;
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with TICK_DIV=10, BLINK_TICKS=3, STRETCH_TICKS=2, CHANNELS=2.
// Cycle e = e-th rising edge after reset release; outputs are sampled 1 time unit after that edge.
module tb_led_status_ctrl;

    localparam int CH = 2;
    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2*CH-1:0] mode = '0;
    logic [CH-1:0] activity = '0;
    logic [CH-1:0] led;
    logic          tick_o;
`ifdef LED_PWM_EN
    logic [PB*CH-1:0] brightness = '0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    led_status_ctrl #(
        .CHANNELS     (CH),
        .TICK_DIV     (10),
        .BLINK_TICKS  (3),
        .STRETCH_TICKS(2),
        .PWM_BITS     (PB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .activity  (activity),
`ifdef LED_PWM_EN
        .brightness(brightness),
`endif
        .led       (led),
        .tick_o    (tick_o)
    );

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset;
        mode = 4'b0101;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (led !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_led got=%b want=00", led);
        end
        vectors++;
        if (tick_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tick got=%b want=0", tick_o);
        end
        mode = '0;
    endtask

    task automatic test_prescaler;
        logic exp_tick;
        mode = '0;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            goto(e);
            exp_tick = (e % 10 == 0);
            vectors++;
            if (tick_o !== exp_tick) begin
                miscompares++;
                $display("FAIL prescaler_tick e=%0d got=%b want=%b", e, tick_o, exp_tick);
            end
            vectors++;
            if (led !== 2'b00) begin
                miscompares++;
                $display("FAIL prescaler_led e=%0d got=%b want=00", e, led);
            end
        end
    endtask

    task automatic test_blink;
        logic exp0, exp1;
        mode = 4'b0010;
        do_reset();
        for (int e = 1; e <= 95; e++) begin
            goto(e);
            exp0 = (((e - 1) / 30) % 2 == 0);
            exp1 = (e >= 46) ? exp0 : 1'b0;
            vectors++;
            if (led !== {exp1, exp0}) begin
                miscompares++;
                $display("FAIL blink e=%0d got=%b want=%b%b", e, led, exp1, exp0);
            end
            if (e == 45) mode = 4'b1010;
        end
    endtask

    task automatic test_activity;
        logic exp0;
        mode = 4'b0011;
        do_reset();
        for (int e = 1; e <= 44; e++) begin
            goto(e);
            exp0 = (e <= 6) || (e >= 23 && e <= 43);
            vectors++;
            if (led !== {1'b0, exp0}) begin
                miscompares++;
                $display("FAIL activity e=%0d got=%b want=0%b", e, led, exp0);
            end
            activity = (e == 5 || e == 42) ? 2'b01 : 2'b00;
        end
        activity = '0;
    endtask

    task automatic test_pending;
        logic exp0;
        mode = 4'b0011;
        do_reset();
        for (int e = 1; e <= 90; e++) begin
            goto(e);
            exp0 = (e <= 6) || (e >= 23 && e <= 42) || (e >= 63);
            vectors++;
            if (led !== {1'b0, exp0}) begin
                miscompares++;
                $display("FAIL pending e=%0d got=%b want=0%b", e, led, exp0);
            end
            activity = (e == 5 || e == 24 || e == 49) ? 2'b01 : 2'b00;
        end
        activity = '0;
    endtask

    task automatic test_simultaneous;
        logic exp0, exp1;
        mode = 4'b1101;
        do_reset();
        for (int e = 1; e <= 92; e++) begin
            goto(e);
            exp0 = (e <= 90);
            exp1 = (e <= 11) || (e >= 33);
            vectors++;
            if (led !== {exp1, exp0}) begin
                miscompares++;
                $display("FAIL simultaneous e=%0d got=%b want=%b%b", e, led, exp1, exp0);
            end
            activity = (e == 10) ? 2'b10 : 2'b00;
            if (e == 60) mode = 4'b1110;
        end
        activity = '0;
    endtask

    task automatic test_mode_exit;
        logic exp0;
        mode = 4'b0111;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            goto(e);
            exp0 = (e <= 5) || (e >= 10);
            vectors++;
            if (led !== {1'b1, exp0}) begin
                miscompares++;
                $display("FAIL mode_exit e=%0d got=%b want=1%b", e, led, exp0);
            end
            activity = (e == 4) ? 2'b01 : 2'b00;
            if (e == 8) mode = 4'b0100;
            if (e == 9) mode = 4'b0111;
        end
        activity = '0;
    endtask

    task automatic test_reset_mid;
        mode = 4'b1011;
        do_reset();
        for (int e = 1; e <= 39; e++) begin
            goto(e);
            activity = (e == 34) ? 2'b01 : 2'b00;
        end
        vectors++;
        if (led !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_pre got=%b want=00", led);
        end
        rst = 1'b1;
        goto(40);
        rst = 1'b0;
        vectors++;
        if (led !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_led got=%b want=00", led);
        end
        vectors++;
        if (tick_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_tick got=%b want=0", tick_o);
        end
        cyc = 0;
        for (int e = 1; e <= 12; e++) begin
            goto(e);
            vectors++;
            if (led !== 2'b11) begin
                miscompares++;
                $display("FAIL reset_mid_restart e=%0d got=%b want=11", e, led);
            end
            vectors++;
            if (tick_o !== (e == 10)) begin
                miscompares++;
                $display("FAIL reset_mid_tick e=%0d got=%b want=%b", e, tick_o, (e == 10));
            end
        end
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm;
        int n0, n1;
        mode       = 4'b0101;
        brightness = {4'd0, 4'd4};
        do_reset();
        n0 = 0;
        n1 = 0;
        for (int e = 5; e <= 20; e++) begin
            goto(e);
            n0 += int'(led[0]);
            n1 += int'(led[1]);
            if (e == 20) brightness = {4'd0, 4'd15};
        end
        vectors++;
        if (n0 !== 4) begin
            miscompares++;
            $display("FAIL pwm_b4 got=%0d want=4", n0);
        end
        vectors++;
        if (n1 !== 0) begin
            miscompares++;
            $display("FAIL pwm_b0 got=%0d want=0", n1);
        end
        n0 = 0;
        for (int e = 21; e <= 36; e++) begin
            goto(e);
            n0 += int'(led[0]);
        end
        vectors++;
        if (n0 !== 15) begin
            miscompares++;
            $display("FAIL pwm_b15 got=%0d want=15", n0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_prescaler();
        test_blink();
        test_activity();
        test_pending();
        test_simultaneous();
        test_mode_exit();
        test_reset_mid();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
